// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM encoding and the
// duration value that marks the end of a song in ROM.
package song_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_PLAYING,
        S_DONE
    } state_t;

    localparam int unsigned END_MARKER = 0;

    function automatic logic state_busy(input state_t s);
        return !((s == S_IDLE) || (s == S_DONE));
    endfunction

endpackage

// File: rtl/song_sequencer_counter_n.sv
// Generic modulo-N counter; tc is high in the cycle the count reaches N-1
// while enabled, so an enabled span of N cycles ends with one tc.
module counter_n #(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count;

    assign tc = en && (count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks an external note ROM for the selected song, presents
// each note with a pulse and advances on note_done until the end marker.
module song_sequencer
    import song_pkg::*;
#(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned NOTE_W    = 6,
    parameter int unsigned DUR_W     = 6,
    parameter int unsigned ROM_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           loop,
    input  logic [SONG_BITS-1:0]           song,
    input  logic                           note_done,
    output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]        rom_data,
    output logic [NOTE_W-1:0]              note,
    output logic [DUR_W-1:0]               duration,
    output logic                           new_note,
    output logic                           song_done,
    output logic                           busy
);

    state_t                 state, state_n;
    logic [ADDR_BITS-1:0]   idx, idx_n;
    logic [SONG_BITS-1:0]   song_q, song_q_n;
    logic [NOTE_W-1:0]      note_n;
    logic [DUR_W-1:0]       dur_n;
    logic                   new_note_n, song_done_n;
    logic                   take_end;
    logic                   wait_en, wait_clr, lat_done;

    logic [NOTE_W-1:0]      rom_note;
    logic [DUR_W-1:0]       rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    assign wait_en  = (state == S_WAIT);
    assign wait_clr = (state != S_WAIT);

    counter_n #(.N(ROM_LAT)) u_lat (
        .clk   (clk),
        .reset (reset),
        .clear (wait_clr),
        .en    (wait_en),
        .tc    (lat_done)
    );

    assign busy = state_busy(state);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        song_q_n    = song_q;
        note_n      = note;
        dur_n       = duration;
        new_note_n  = 1'b0;
        song_done_n = 1'b0;
        take_end    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (play) begin
                    song_q_n = song;
                    idx_n    = '0;
                    state_n  = S_FETCH;
                end
            end
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                if (lat_done) state_n = S_PRESENT;
            end
            S_PRESENT: begin
                if (rom_dur == DUR_W'(END_MARKER)) begin
                    take_end = 1'b1;
                end else begin
                    note_n     = rom_note;
                    dur_n      = rom_dur;
                    new_note_n = 1'b1;
                    state_n    = S_PLAYING;
                end
            end
            S_PLAYING: begin
                if (note_done) begin
                    if (idx == '1) begin
                        take_end = 1'b1;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            S_DONE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase

        // Both end conditions (marker in PRESENT, last index in PLAYING) share one exit.
        if (take_end) begin
            song_done_n = 1'b1;
            if (loop) begin
                idx_n   = '0;
                state_n = S_FETCH;
            end else begin
                state_n = S_DONE;
            end
        end

        if ((state != S_IDLE) && !play) begin
            state_n     = S_IDLE;
            idx_n       = '0;
            note_n      = '0;
            dur_n       = '0;
            new_note_n  = 1'b0;
            song_done_n = 1'b0;
        end
    end

    // rom_addr tracks {song_q, idx} one cycle ahead so it is valid in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            song_q    <= '0;
            rom_addr  <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            song_q    <= song_q_n;
            rom_addr  <= {song_q_n, idx_n};
            note      <= note_n;
            duration  <= dur_n;
            new_note  <= new_note_n;
            song_done <= song_done_n;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: dut_a uses ROM_LAT=1, dut_b uses ROM_LAT=3; expected note
// pulses are queued by stimulus and matched by a monitor at each negedge.
module tb_song_sequencer;

    typedef struct {
        logic [5:0] n;
        logic [5:0] d;
        int         c;
    } exp_t;

    logic        clk;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    logic [11:0] rom [0:127];

    logic        rst_a, play_a, loop_a, nd_a;
    logic [1:0]  song_a;
    logic [6:0]  addr_a;
    logic [11:0] rd_a;
    logic [5:0]  note_a, dur_a;
    logic        nn_a, sd_a, busy_a;

    logic        rst_b, play_b, loop_b, nd_b;
    logic [1:0]  song_b;
    logic [6:0]  addr_b;
    logic [11:0] rd_b;
    logic [5:0]  note_b, dur_b;
    logic        nn_b, sd_b, busy_b;

    logic [11:0] pipe_b [0:2];

    exp_t        qa[$];
    exp_t        qb[$];
    int          sda_q[$];

    song_sequencer dut_a (
        .clk(clk), .reset(rst_a), .play(play_a), .loop(loop_a), .song(song_a),
        .note_done(nd_a), .rom_addr(addr_a), .rom_data(rd_a), .note(note_a),
        .duration(dur_a), .new_note(nn_a), .song_done(sd_a), .busy(busy_a)
    );

    song_sequencer #(.ROM_LAT(3)) dut_b (
        .clk(clk), .reset(rst_b), .play(play_b), .loop(loop_b), .song(song_b),
        .note_done(nd_b), .rom_addr(addr_b), .rom_data(rd_b), .note(note_b),
        .duration(dur_b), .new_note(nn_b), .song_done(sd_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_a      <= rom[addr_a];
        pipe_b[0] <= rom[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rd_b = pipe_b[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic to_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_a(input int a, input int c);
        qa.push_back('{rom[a][11:6], rom[a][5:0], c});
    endtask

    task automatic start_a(input logic [1:0] s, input logic lp, output int n);
        int c;
        @(posedge clk); #1;
        song_a = s; loop_a = lp; play_a = 1'b1;
        c = cyc;
        n = c + 4;
        push_a(int'(s) * 32, n);
        to_neg(c + 1);
        chk("fetch_addr_a", addr_a, int'(s) * 32);
        chk("fetch_busy_a", busy_a, 1);
    endtask

    task automatic pulse_nd_a(input int at, output int d);
        to_neg(at - 1);
        @(posedge clk); #1;
        nd_a = 1'b1;
        d = cyc;
        @(posedge clk); #1;
        nd_a = 1'b0;
    endtask

    task automatic drop_a(output int e);
        @(posedge clk); #1;
        play_a = 1'b0;
        e = cyc;
    endtask

    initial begin
        for (int a = 0; a < 128; a++)
            rom[a] = {6'(a % 32 + (a / 32) * 13 + 1), 6'(a % 32 + a / 32 + 1)};
        rom[64] = {6'd5, 6'd10};
        rom[35] = {6'd9, 6'd0};

        rst_a = 1'b1; play_a = 1'b1; loop_a = 1'b0; nd_a = 1'b1; song_a = 2'd3;
        rst_b = 1'b1; play_b = 1'b1; loop_b = 1'b0; nd_b = 1'b0; song_b = 2'd0;

        fork
            begin : monitor
                exp_t e;
                int   sc;
                forever begin
                    @(negedge clk);
                    if (nn_a) begin
                        checks++;
                        if (qa.size() == 0) begin
                            fails++;
                            $display("FAIL nn_a_unexpected actual=%0d/%0d required=none (cyc %0d)", note_a, dur_a, cyc);
                        end else begin
                            e = qa.pop_front();
                            if (note_a !== e.n || dur_a !== e.d || cyc != e.c) begin
                                fails++;
                                $display("FAIL nn_a actual=%0d/%0d@%0d required=%0d/%0d@%0d", note_a, dur_a, cyc, e.n, e.d, e.c);
                            end
                        end
                    end
                    if (sd_a) begin
                        checks++;
                        if (sda_q.size() == 0) begin
                            fails++;
                            $display("FAIL sd_a_unexpected actual=1 required=0 (cyc %0d)", cyc);
                        end else begin
                            sc = sda_q.pop_front();
                            if (cyc != sc) begin
                                fails++;
                                $display("FAIL sd_a actual=@%0d required=@%0d", cyc, sc);
                            end
                        end
                    end
                    if (nn_a && sd_a) begin
                        checks++; fails++;
                        $display("FAIL nn_sd_overlap actual=1 required=0 (cyc %0d)", cyc);
                    end
                    if (nn_b) begin
                        checks++;
                        if (qb.size() == 0) begin
                            fails++;
                            $display("FAIL nn_b_unexpected actual=%0d/%0d required=none (cyc %0d)", note_b, dur_b, cyc);
                        end else begin
                            e = qb.pop_front();
                            if (note_b !== e.n || dur_b !== e.d || cyc != e.c) begin
                                fails++;
                                $display("FAIL nn_b actual=%0d/%0d@%0d required=%0d/%0d@%0d", note_b, dur_b, cyc, e.n, e.d, e.c);
                            end
                        end
                    end
                    if (sd_b) begin
                        checks++; fails++;
                        $display("FAIL sd_b_unexpected actual=1 required=0 (cyc %0d)", cyc);
                    end
                end
            end

            begin : stimulus
                int n, d, e, c;

                // reset overrides play and note_done
                to_neg(2);
                chk("reset_a", {addr_a, note_a, dur_a, nn_a, sd_a, busy_a}, 0);
                chk("reset_b", {addr_b, note_b, dur_b, nn_b, sd_b, busy_b}, 0);
                @(posedge clk); #1;
                rst_a = 1'b0; play_a = 1'b0; nd_a = 1'b0;
                rst_b = 1'b0; play_b = 1'b0;

                // full song 2, no loop: 32 notes then song_done and DONE
                start_a(2'd2, 1'b0, n);
                for (int i = 1; i < 32; i++) begin
                    pulse_nd_a(n + 1, d);
                    n = d + 4;
                    push_a(64 + i, n);
                end
                pulse_nd_a(n + 1, d);
                sda_q.push_back(d + 1);
                to_neg(d + 2);
                chk("done_busy", busy_a, 0);
                chk("done_note", note_a, 58);
                chk("done_dur", dur_a, 34);
                pulse_nd_a(d + 3, c);
                to_neg(c + 5);
                chk("done_hold_note", note_a, 58);
                drop_a(e);
                to_neg(e + 1);
                chk("idle_note", note_a, 0);
                chk("idle_dur", dur_a, 0);
                chk("idle_busy", busy_a, 0);

                // song 1 with end marker at note 3, looping
                start_a(2'd1, 1'b1, n);
                pulse_nd_a(n + 1, d); n = d + 4; push_a(33, n);
                pulse_nd_a(n + 1, d); n = d + 4; push_a(34, n);
                pulse_nd_a(n + 1, d);
                sda_q.push_back(d + 4);
                push_a(32, d + 7);
                to_neg(d + 4);
                chk("loop_addr", addr_a, 32);
                n = d + 7;

                // play drops together with note_done
                to_neg(n);
                @(posedge clk); #1;
                nd_a = 1'b1; play_a = 1'b0;
                c = cyc;
                @(posedge clk); #1;
                nd_a = 1'b0;
                chk("abort_note", note_a, 0);
                chk("abort_busy", busy_a, 0);
                chk("abort_addr", addr_a, 32);
                to_neg(c + 8);

                // song change during playback is ignored
                start_a(2'd1, 1'b0, n);
                to_neg(n);
                song_a = 2'd3;
                pulse_nd_a(n + 1, d);
                n = d + 4;
                push_a(33, n);
                to_neg(d + 1);
                chk("keep_song_addr", addr_a, 33);
                to_neg(n);
                drop_a(e);
                start_a(2'd3, 1'b0, n);
                to_neg(n + 1);
                drop_a(e);

                // ROM_LAT=3 latency, then reset during WAIT
                @(posedge clk); #1;
                play_b = 1'b1; song_b = 2'd0;
                c = cyc;
                qb.push_back('{6'd1, 6'd1, c + 6});
                to_neg(c + 1);
                chk("fetch_addr_b", addr_b, 0);
                to_neg(c + 6);
                @(posedge clk); #1;
                nd_b = 1'b1;
                d = cyc;
                @(posedge clk); #1;
                nd_b = 1'b0;
                @(posedge clk); #1;
                rst_b = 1'b1; play_b = 1'b0;
                @(posedge clk); #1;
                rst_b = 1'b0;
                chk("rst_wait_b", {addr_b, note_b, dur_b, nn_b, sd_b, busy_b}, 0);
                to_neg(d + 14);
                chk("rst_wait_b_idle", busy_b, 0);

                chk("qa_empty", qa.size(), 0);
                chk("qb_empty", qb.size(), 0);
                chk("sda_empty", sda_q.size(), 0);
            end

            begin : watchdog
                #200000;
                fails++;
                $display("FAIL watchdog actual=timeout required=completion");
            end
        join_any
        disable fork;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter SONG_BITS, default 2: song-select width, giving 2**SONG_BITS songs.
REQ-002 SHALL have parameter ADDR_BITS, default 5: note-index width, giving 2**ADDR_BITS notes per song.
REQ-003 SHALL have parameter NOTE_W, default 6: note code width.
REQ-004 SHALL have parameter DUR_W, default 6: duration width.
REQ-005 SHALL have parameter ROM_LAT, default 1, legal range 1..4: ROM read latency in clk cycles.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port play, input, 1: high requests playback; low aborts playback.
REQ-009 SHALL have port loop, input, 1: when high, the song restarts at note 0 after its end.
REQ-010 SHALL have port song, input, SONG_BITS: song select, sampled only at start of playback.
REQ-011 SHALL have port note_done, input, 1: one-cycle pulse; the current note has finished and the next note is requested.
REQ-012 SHALL have port rom_addr, output, SONG_BITS+ADDR_BITS: registered read address, {song_q, idx}.
REQ-013 SHALL have port rom_data, input, NOTE_W+DUR_W: {note, duration}, valid ROM_LAT cycles after rom_addr.
REQ-014 SHALL have port note, output, NOTE_W: current note code, registered.
REQ-015 SHALL have port duration, output, DUR_W: current note duration, registered.
REQ-016 SHALL have port new_note, output, 1: one-cycle pulse when note/duration are updated.
REQ-017 SHALL have port song_done, output, 1: one-cycle pulse at end of song.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE and DONE.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT, PRESENT, PLAYING and DONE.
REQ-020 IDLE with play=1 SHALL latch song into song_q, set idx=0 and go to FETCH next cycle.
REQ-021 FETCH SHALL drive rom_addr={song_q,idx} and go to WAIT.
REQ-022 WAIT SHALL count ROM_LAT cycles and then go to PRESENT.
REQ-023 PRESENT with rom_data duration field=0 SHALL be the end-of-song marker and take the end path (REQ-027).
REQ-024 PRESENT with nonzero duration SHALL register note and duration, pulse new_note once and go to PLAYING.
REQ-025 Fetch-to-new_note latency SHALL be ROM_LAT+2 cycles after entering FETCH.
REQ-026 PLAYING with note_done=1: if idx=2**ADDR_BITS-1, take the end path; else idx+1 and go to FETCH.
REQ-027 End path SHALL pulse song_done once and then:
  - loop=1: idx=0, go to FETCH;
  - loop=0: go to DONE.
REQ-028 DONE SHALL hold note and duration until play=0, then go to IDLE.
REQ-029 play=0 in any non-IDLE state SHALL force IDLE next cycle, clear idx, note and duration, and suppress new_note and song_done that cycle; play=0 has priority over note_done.
REQ-030 note_done outside PLAYING SHALL be ignored, with no queuing.
REQ-031 Changes on song during playback SHALL be ignored until the next IDLE->FETCH transition.
REQ-032 idx SHALL be ADDR_BITS wide with no carry-out, and SHALL never wrap implicitly; the end is decided by REQ-026.
REQ-033 new_note and song_done SHALL never both be high in the same cycle.

Reset
REQ-034 reset=1 SHALL, on the next clk edge, force:
  - state=IDLE;
  - idx=0, song_q=0, rom_addr=0;
  - note=0, duration=0;
  - new_note=0, song_done=0, busy=0.
REQ-035 reset SHALL override play, note_done and all in-flight ROM reads.
REQ-036 reset asserted mid-operation SHALL discard all pending reads, with no pulse emitted afterwards.

Structure
REQ-037 FSM state encoding and the END_MARKER duration constant (0) SHALL live in shared package song_pkg.
REQ-038 The ROM read-latency counter SHALL be instantiated from the existing generic counter_n (n=ROM_LAT); no other sub-module; the ROM is external.

Verification
REQ-039 Default params, song=2, ROM note 0 = {5,10}, play=1 -> rom_addr=64 at FETCH; new_note pulses 3 cycles after FETCH with note=5, duration=10.
REQ-040 All 32 durations nonzero, loop=0, 32 note_done pulses -> exactly 32 new_note pulses, then one song_done pulse, state DONE, note held; play=0 -> IDLE.
REQ-041 Note 3 has duration 0, loop=1 -> song_done after note 2's note_done, then rom_addr returns to {song,0} and new_note repeats note 0.
REQ-042 play drops in the same cycle as note_done -> no FETCH; IDLE next cycle, note=0, no pulse.
REQ-043 ROM_LAT=3 -> new_note 5 cycles after FETCH; reset asserted during WAIT -> IDLE and all outputs zero next cycle, no later new_note.
REQ-044 song changed 1->3 while PLAYING -> rom_addr keeps song 1 until replay from IDLE.
